// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state codes, screen constants and score helper
package game_pkg;

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'b00,
        ST_PLAY    = 2'b01,
        ST_OVER    = 2'b10,
        ST_PAUSE   = 2'b11
    } game_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Unsigned compare; a tie keeps the current best.
    function automatic logic [5:0] score_max(input logic [5:0] best, input logic [5:0] cand);
        return (cand > best) ? cand : best;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, debounce counter and press event
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_MS);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // The counter tallies consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_MS - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game sequencer: FSM, round timer, scores and restart pulse
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_MS  = 20,
    parameter int OVER_MIN_MS  = 1000,
    parameter int OVER_HOLD_MS = 5000,
    parameter int RST_PULSE    = 2,
    parameter int BLINK_MS     = 250
) (
    input  logic       clk_1ms,
    input  logic       reset,
    input  logic       startBtn,
    input  logic       pauseBtn,
    input  logic [5:0] gameOver,
    input  logic [5:0] scoreCounter,
    output logic [1:0] game_state,
    output logic       round_rst_n,
    output logic [5:0] high_score,
    output logic [5:0] last_score,
    output logic [9:0] round_secs,
    output logic       over_blink
);
    localparam int DW = $clog2(OVER_HOLD_MS);
    localparam int BW = $clog2(BLINK_MS);
    localparam int PW = $clog2(RST_PULSE + 1);

    game_state_e   r_state, w_next;
    logic          w_start_ev, w_pause_ev;
    logic [DW-1:0] r_dwell;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;
    logic [PW-1:0] r_rst_cnt;
    logic [9:0]    r_ms, r_secs;
    logic [5:0]    r_high, r_last;

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
        .clk(clk_1ms), .rst_n(reset), .i_btn(startBtn), .o_press(w_start_ev)
    );
    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause_db (
        .clk(clk_1ms), .rst_n(reset), .i_btn(pauseBtn), .o_press(w_pause_ev)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ATTRACT: if (w_start_ev) w_next = ST_PLAY;
            ST_PLAY: begin
                // Entity outputs are stale while the restart pulse is in flight.
                if (r_rst_cnt == '0 && gameOver != 6'd0) w_next = ST_OVER;
                else if (w_pause_ev)                     w_next = ST_PAUSE;
            end
            ST_PAUSE: if (w_pause_ev || w_start_ev) w_next = ST_PLAY;
            ST_OVER: begin
                if ((w_start_ev && r_dwell >= DW'(OVER_MIN_MS)) ||
                    r_dwell == DW'(OVER_HOLD_MS - 1))
                    w_next = ST_ATTRACT;
            end
            default: w_next = ST_ATTRACT;
        endcase
    end

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ATTRACT;
            r_dwell     <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_rst_cnt   <= '0;
            r_ms        <= '0;
            r_secs      <= '0;
            r_high      <= '0;
            r_last      <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_ATTRACT: begin
                    if (w_next == ST_PLAY) begin
                        r_ms      <= '0;
                        r_secs    <= '0;
                        r_rst_cnt <= PW'(RST_PULSE);
                    end
                end
                ST_PLAY: begin
                    if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - PW'(1);
                    if (r_ms == 10'd999) begin
                        r_ms <= '0;
                        if (r_secs != 10'd1023) r_secs <= r_secs + 10'd1;
                    end else begin
                        r_ms <= r_ms + 10'd1;
                    end
                    if (w_next == ST_OVER) begin
                        r_last      <= scoreCounter;
                        r_high      <= score_max(r_high, scoreCounter);
                        r_dwell     <= '0;
                        r_blink_cnt <= '0;
                        r_blink     <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (w_next != ST_OVER) begin
                        r_blink <= 1'b0;
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                        if (r_blink_cnt == BW'(BLINK_MS - 1)) begin
                            r_blink_cnt <= '0;
                            r_blink     <= ~r_blink;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + BW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign game_state  = r_state;
    assign round_rst_n = (r_state == ST_PLAY || r_state == ST_PAUSE) && (r_rst_cnt == '0);
    assign high_score  = r_high;
    assign last_score  = r_last;
    assign round_secs  = r_secs;
    assign over_blink  = (r_state == ST_OVER) && r_blink;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed plus randomized self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

    localparam logic [1:0] S_ATTRACT = 2'b00;
    localparam logic [1:0] S_PLAY    = 2'b01;
    localparam logic [1:0] S_OVER    = 2'b10;
    localparam logic [1:0] S_PAUSE   = 2'b11;

    logic       clk_1ms = 1'b0;
    logic       reset = 1'b0;
    logic       startBtn = 1'b0;
    logic       pauseBtn = 1'b0;
    logic [5:0] gameOver = 6'd0;
    logic [5:0] scoreCounter = 6'd0;
    logic [1:0] game_state;
    logic       round_rst_n;
    logic [5:0] high_score;
    logic [5:0] last_score;
    logic [9:0] round_secs;
    logic       over_blink;

    int errors = 0;
    int checks = 0;
    int play_edges = 0;
    int model_high = 0;
    int model_last = 0;
    int start_evs = 0;

    game_state_ctrl dut (
        .clk_1ms(clk_1ms), .reset(reset), .startBtn(startBtn), .pauseBtn(pauseBtn),
        .gameOver(gameOver), .scoreCounter(scoreCounter), .game_state(game_state),
        .round_rst_n(round_rst_n), .high_score(high_score), .last_score(last_score),
        .round_secs(round_secs), .over_blink(over_blink)
    );

    always #5 clk_1ms = ~clk_1ms;

    always @(posedge clk_1ms) if (dut.w_start_ev === 1'b1) start_evs++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (game_state == S_PLAY) play_edges++;
        @(posedge clk_1ms);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic start_round();
        int n;
        n = 0;
        startBtn = 1'b1;
        while (game_state != S_PLAY && n < 40) begin step(); n++; end
        chk("start_to_play", game_state, S_PLAY);
        play_edges = 0;
        chk("restart_low", round_rst_n, 0);
        gameOver = 6'h0F;
        step();
        chk("gameover_ignored_in_pulse", game_state, S_PLAY);
        gameOver = 6'd0;
        startBtn = 1'b0;
    endtask

    task automatic end_round(input int score);
        scoreCounter = 6'(score);
        gameOver = 6'($urandom_range(1, 63));
        step();
        if (score > model_high) model_high = score;
        model_last = score;
        chk("enter_over", game_state, S_OVER);
        chk("last_score", last_score, model_last);
        chk("high_score", high_score, model_high);
        chk("blink_on_entry", over_blink, 1);
        gameOver = 6'd0;
    endtask

    task automatic exit_over();
        int n;
        steps(1000);
        startBtn = 1'b1;
        n = 0;
        while (game_state != S_ATTRACT && n < 40) begin step(); n++; end
        chk("over_exit_by_start", game_state, S_ATTRACT);
        chk("restart_low_attract", round_rst_n, 0);
        startBtn = 1'b0;
        steps(25);
    endtask

    initial begin
        int n, ev0, saved, score, len;
        logic bad;

        // 1: reset state
        steps(5);
        chk("rst_state", game_state, S_ATTRACT);
        chk("rst_restart", round_rst_n, 0);
        chk("rst_high", high_score, 0);
        chk("rst_last", last_score, 0);
        chk("rst_secs", round_secs, 0);
        chk("rst_blink", over_blink, 0);
        reset = 1'b1;
        step();
        chk("post_rst_state", game_state, S_ATTRACT);

        // 2: bounce never reaches the debounce count; stable level starts a round
        ev0 = start_evs;
        for (int i = 0; i < 5; i++) begin
            startBtn = (i % 2 == 1);
            steps(3);
        end
        chk("bounce_no_start", game_state, S_ATTRACT);
        startBtn = 1'b1;
        n = 0;
        while (game_state != S_PLAY && n < 40) begin step(); n++; end
        // 2 sync stages + 20 stable samples + 1 FSM cycle
        chk("start_latency", n, 23);
        play_edges = 0;
        chk("pulse_cyc0", round_rst_n, 0);
        step();
        chk("pulse_cyc1", round_rst_n, 0);
        step();
        chk("pulse_done", round_rst_n, 1);
        steps(60);
        chk("one_start_event", start_evs - ev0, 1);
        startBtn = 1'b0;
        steps(30);

        // 3: two rounds, second lower score
        end_round(13);
        exit_over();
        start_round();
        steps(50);
        end_round(9);
        chk("high_kept", high_score, 13);
        exit_over();

        // 4: round timer and pause freeze
        start_round();
        steps(2500 - play_edges);
        chk("secs_2500", round_secs, play_edges / 1000);
        pauseBtn = 1'b1;
        n = 0;
        while (game_state != S_PAUSE && n < 40) begin step(); n++; end
        chk("enter_pause", game_state, S_PAUSE);
        pauseBtn = 1'b0;
        saved = play_edges / 1000;
        steps(3000);
        chk("pause_held", game_state, S_PAUSE);
        chk("pause_frozen", round_secs, saved);
        pauseBtn = 1'b1;
        n = 0;
        bad = 1'b0;
        while (game_state != S_PLAY && n < 40) begin
            step(); n++;
            if (round_rst_n !== 1'b1) bad = 1'b1;
        end
        chk("resume_play", game_state, S_PLAY);
        chk("resume_no_restart", bad, 0);
        pauseBtn = 1'b0;
        steps(30);
        chk("secs_after_resume", round_secs, play_edges / 1000);

        // 5: early start dropped, timeout, blink cadence
        end_round($urandom_range(0, 63));
        for (int t = 1; t <= 5000; t++) begin
            if (t == 480) startBtn = 1'b1;
            if (t == 520) startBtn = 1'b0;
            step();
            if (t < 5000 && (t % 250 == 0 || t % 250 == 249))
                chk("blink", over_blink, ((t / 250) % 2 == 0) ? 1 : 0);
            if (t == 1000 || t == 4999) chk("over_dwell", game_state, S_OVER);
            if (t == 5000) begin
                chk("over_timeout", game_state, S_ATTRACT);
                chk("blink_off", over_blink, 0);
            end
        end
        steps(5);

        // randomized rounds against the max/last model
        for (int r = 0; r < 6; r++) begin
            start_round();
            len = $urandom_range(30, 2600);
            steps(len);
            chk("rand_secs", round_secs, play_edges / 1000);
            score = (r == 2) ? model_high : $urandom_range(0, 63);
            end_round(score);
            exit_over();
        end

        // 6: gameOver beats pause in the same cycle; async reset mid-round
        start_round();
        steps(40);
        pauseBtn = 1'b1;
        n = 0;
        while (dut.w_pause_ev !== 1'b1 && n < 40) begin step(); n++; end
        chk("pause_event_seen", dut.w_pause_ev, 1);
        end_round($urandom_range(0, 63));
        pauseBtn = 1'b0;
        exit_over();
        start_round();
        steps(100);
        reset = 1'b0;
        #2;
        chk("async_rst_state", game_state, S_ATTRACT);
        chk("async_rst_high", high_score, 0);
        chk("async_rst_restart", round_rst_n, 0);
        chk("async_rst_secs", round_secs, 0);
        @(posedge clk_1ms);
        #1;
        reset = 1'b1;
        step();
        chk("after_rst_state", game_state, S_ATTRACT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
